exec_sequencer: RTL and testbench
=================================

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset and on start.
REQ-002 Parameter PC_STEP, default 4: PC increment per retired instruction.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  single-cycle pulse; leaves IDLE and begins fetching at RESET_PC.
REQ-006 halt_req  input  1  level request to stop at the next instruction boundary.
REQ-007 imem_req  output  1  fetch request, held until accepted.
REQ-008 imem_addr  output  32  fetch address; equals pc.
REQ-009 imem_valid  input  1  fetch data valid; completes the request.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 dec_instr  output  32  instruction register, driven to the field extractor and decode control.
REQ-012 dec_legal  input  1  decoder verdict for dec_instr; 1 means a supported opcode/funct combination.
REQ-013 dec_wb_we  input  1  decoder write-back enable for dec_instr.
REQ-014 rf_re  output  1  register-file read strobe.
REQ-015 alu_en  output  1  ALU operand/result capture strobe.
REQ-016 rf_we  output  1  register-file write strobe.
REQ-017 pc  output  32  address of the current instruction.
REQ-018 busy  output  1  high in every state except IDLE and HALT.
REQ-019 illegal  output  1  sticky flag; set on an illegal instruction.
REQ-020 instret  output  32  retired-instruction count (see Configuration).

Function
REQ-021 FSM states SHALL be IDLE, FETCH, DECODE, EXEC, WB and HALT.
REQ-022 IDLE->FETCH on start; pc<=RESET_PC, illegal<=0, and instret<=0 if present.
REQ-023 FETCH: imem_req=1, with imem_addr stable until imem_valid. On imem_valid, ir<=imem_rdata and the FSM goes to DECODE. A same-cycle valid is legal, giving a one-cycle FETCH.
REQ-024 DECODE (1 cycle): rf_re=1 and dec_legal is sampled. If 0, illegal<=1 and the FSM goes to HALT with pc unchanged; else the FSM goes to EXEC and dec_wb_we is latched.
REQ-025 EXEC (1 cycle): alu_en=1, then the FSM goes to WB.
REQ-026 WB (1 cycle): rf_we = the latched wb_we. pc<=pc+PC_STEP, modulo 2^32, wrapping 32'hFFFF_FFFC->0 with no flag. instret increments. Then HALT if halt_req=1, else FETCH.
REQ-027 Minimum latency is 4 cycles per instruction with zero-wait memory.
REQ-028 halt_req SHALL be honoured only in WB; it is ignored in FETCH/DECODE/EXEC, so the instruction in flight always completes.
REQ-029 HALT->FETCH on start, resuming at the current pc with illegal cleared. HALT ignores halt_req.
REQ-030 start while busy SHALL be ignored.
REQ-031 rf_re, alu_en, rf_we and imem_req SHALL be mutually exclusive, and each SHALL be high only in its own state.
REQ-032 instret SHALL saturate at 32'hFFFF_FFFF.

Reset
REQ-033 Asserting rst_n low at any time, including mid-fetch, SHALL immediately force: state=IDLE, pc=RESET_PC, ir=0, illegal=0, instret=0 and all strobes 0. No pending fetch is remembered.
REQ-034 The first state change after deassertion SHALL require start.

Configuration
REQ-035 Macro EXEC_SEQUENCER_INSTRET_EN defined: instret is a live 32-bit counter per REQ-026/REQ-032.
REQ-036 Macro undefined: the instret port remains present and is tied to 0, and no counter flops are inferred.

Structure
REQ-037 The shared package SHALL hold the state enum type, PC_STEP_DEFAULT and RESET_PC_DEFAULT.
REQ-038 One sub-module, exec_seq_pc_unit, SHALL hold the pc register, increment/wrap logic and the optional instret counter. The FSM stays in the top module.

Verification
REQ-039 Reset then start, zero-wait memory, all instructions legal with dec_wb_we=1: imem_addr sequence 0,4,8, with rf_we pulsing every 4th cycle.
REQ-040 imem_valid delayed 3 cycles: imem_req and imem_addr held constant for 4 cycles, and ir captured only on the valid cycle.
REQ-041 dec_legal=0 at pc=8: illegal=1, state HALT, pc=8, rf_we never asserted; a later start refetches 8 with illegal=0.
REQ-042 halt_req raised during EXEC of pc=4: WB completes, pc=8, then HALT, busy=0, and no further imem_req.
REQ-043 RESET_PC=32'hFFFF_FFF8: pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-044 rst_n pulsed low mid-FETCH: outputs return to reset values asynchronously, and imem_req drops before the next clk edge.

Source files
------------

// File: rtl/exec_sequencer_pkg.sv
// Shared types and defaults for the exec_sequencer instruction sequencer.
package exec_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } seq_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEFAULT  = 4;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Instruction-memory fetch handshake between the sequencer (master) and memory (slave).
interface exec_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_valid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_valid, imem_rdata);
endinterface

// File: rtl/exec_seq_pc_unit.sv
// Program counter with wrap-around increment and optional saturating retire counter.
// Counter present only when EXEC_SEQUENCER_INSTRET_EN is defined.
module exec_seq_pc_unit
  import exec_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        advance,
  output logic [31:0] pc,
  output logic [31:0] instret
);

  // Natural 32-bit overflow gives the silent wrap to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pc <= RESET_PC;
    else if (load)    pc <= RESET_PC;
    else if (advance) pc <= pc + 32'(PC_STEP);
  end

`ifdef EXEC_SEQUENCER_INSTRET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       instret <= '0;
    else if (load)    instret <= '0;
    else if (advance) instret <= sat_inc32(instret);
  end
`else
  assign instret = '0;
`endif

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB instruction sequencer; owns the FSM and instruction register.
// Optional retire counter enabled by EXEC_SEQUENCER_INSTRET_EN.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    halt_req,
  exec_sequencer_if.master        imem,
  output logic [31:0]             dec_instr,
  input  logic                    dec_legal,
  input  logic                    dec_wb_we,
  output logic                    rf_re,
  output logic                    alu_en,
  output logic                    rf_we,
  output logic [31:0]             pc,
  output logic                    busy,
  output logic                    illegal,
  output logic [31:0]             instret
);

  seq_state_e  state_q, state_d;
  logic [31:0] ir_q;
  logic        illegal_q;
  logic        wb_we_q;
  logic        pc_load;
  logic        pc_adv;

  exec_seq_pc_unit #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_unit (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (pc_load),
    .advance (pc_adv),
    .pc      (pc),
    .instret (instret)
  );

  always_comb begin
    state_d       = state_q;
    pc_load       = 1'b0;
    pc_adv        = 1'b0;
    rf_re         = 1'b0;
    alu_en        = 1'b0;
    rf_we         = 1'b0;
    imem.imem_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_load = 1'b1;
        end
      end
      ST_FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_valid) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        rf_re   = 1'b1;
        state_d = dec_legal ? ST_EXEC : ST_HALT;
      end
      ST_EXEC: begin
        alu_en  = 1'b1;
        state_d = ST_WB;
      end
      ST_WB: begin
        rf_we   = wb_we_q;
        pc_adv  = 1'b1;
        state_d = halt_req ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        // Resume from the current pc, so no reload here.
        if (start) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      wb_we_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE || state_q == ST_HALT) && start)
        illegal_q <= 1'b0;
      else if (state_q == ST_DECODE && !dec_legal)
        illegal_q <= 1'b1;
      if (state_q == ST_FETCH && imem.imem_valid)
        ir_q <= imem.imem_rdata;
      if (state_q == ST_DECODE && dec_legal)
        wb_we_q <= dec_wb_we;
    end
  end

  assign imem.imem_addr = pc;
  assign dec_instr      = ir_q;
  assign illegal        = illegal_q;
  assign busy           = (state_q != ST_IDLE) && (state_q != ST_HALT);

endmodule

// File: tb/tb_exec_sequencer.sv
// Randomized bench for exec_sequencer against a per-instruction transaction model.
module tb_exec_sequencer;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] STEP    = 32'd4;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt_req, dec_legal, dec_wb_we;
  logic [31:0] dec_instr, pc, instret;
  logic        rf_re, alu_en, rf_we, busy, illegal;

  logic        start2;
  logic [31:0] dec_instr2, pc2, instret2;
  logic        rf_re2, alu_en2, rf_we2, busy2, illegal2;

  exec_sequencer_if bus ();
  exec_sequencer_if bus2 ();

  always #5 clk = ~clk;

  exec_sequencer u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .halt_req  (halt_req),
    .imem      (bus),
    .dec_instr (dec_instr),
    .dec_legal (dec_legal),
    .dec_wb_we (dec_wb_we),
    .rf_re     (rf_re),
    .alu_en    (alu_en),
    .rf_we     (rf_we),
    .pc        (pc),
    .busy      (busy),
    .illegal   (illegal),
    .instret   (instret)
  );

  exec_sequencer #(.RESET_PC(WRAP_PC), .PC_STEP(4)) u_dut_wrap (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start2),
    .halt_req  (1'b0),
    .imem      (bus2),
    .dec_instr (dec_instr2),
    .dec_legal (1'b1),
    .dec_wb_we (1'b1),
    .rf_re     (rf_re2),
    .alu_en    (alu_en2),
    .rf_we     (rf_we2),
    .pc        (pc2),
    .busy      (busy2),
    .illegal   (illegal2),
    .instret   (instret2)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_pc, m_ir, m_instret;
  logic        m_ill;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_instret();
`ifdef EXEC_SEQUENCER_INSTRET_EN
    return m_instret;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_ir = '0; m_ill = 1'b0; m_instret = '0;
  endtask

  task automatic start_seq(input bit from_idle);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (from_idle) begin
      m_pc = RST_PC;
      m_instret = '0;
    end
    m_ill = 1'b0;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_req", bus.imem_req, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_pc", pc, m_pc);
      chk("idle_illegal", illegal, m_ill);
      chk("idle_strobes", {rf_re, alu_en, rf_we}, 3'b000);
      chk("idle_instret", instret, exp_instret());
      halt_req = 1'($urandom);
      @(negedge clk);
    end
    halt_req = 1'b0;
  endtask

  // Drives one instruction from its first FETCH cycle through WB (or HALT on illegal).
  task automatic do_instr(input int wt, input bit legal, input bit wbwe, input bit hlt,
                          output bit halted);
    logic [31:0] word;
    word   = $urandom;
    halted = 1'b0;
    for (int w = 0; w <= wt; w++) begin
      chk("fetch_req", bus.imem_req, 1'b1);
      chk("fetch_addr", bus.imem_addr, m_pc);
      chk("fetch_ir_hold", dec_instr, m_ir);
      chk("fetch_strobes", {rf_re, alu_en, rf_we}, 3'b000);
      chk("fetch_busy", busy, 1'b1);
      chk("fetch_illegal", illegal, m_ill);
      bus.imem_valid = (w == wt);
      bus.imem_rdata = (w == wt) ? word : $urandom;
      halt_req = 1'($urandom);
      start    = 1'($urandom);
      @(negedge clk);
    end
    bus.imem_valid = 1'b0;
    m_ir = word;
    chk("dec_rf_re", rf_re, 1'b1);
    chk("dec_other", {bus.imem_req, alu_en, rf_we}, 3'b000);
    chk("dec_ir", dec_instr, word);
    chk("dec_busy", busy, 1'b1);
    dec_legal = legal;
    dec_wb_we = wbwe;
    halt_req  = 1'($urandom);
    start     = 1'($urandom);
    @(negedge clk);
    dec_legal = 1'($urandom);
    dec_wb_we = 1'($urandom);
    if (!legal) begin
      m_ill = 1'b1;
      start = 1'b0; halt_req = 1'b0;
      chk("ill_busy", busy, 1'b0);
      chk("ill_flag", illegal, 1'b1);
      chk("ill_pc", pc, m_pc);
      chk("ill_strobes", {bus.imem_req, rf_re, alu_en, rf_we}, 4'b0000);
      chk("ill_instret", instret, exp_instret());
      halted = 1'b1;
      return;
    end
    chk("exec_alu_en", alu_en, 1'b1);
    chk("exec_other", {bus.imem_req, rf_re, rf_we}, 3'b000);
    halt_req = hlt;
    start    = 1'($urandom);
    @(negedge clk);
    chk("wb_rf_we", rf_we, wbwe);
    chk("wb_other", {bus.imem_req, rf_re, alu_en}, 3'b000);
    chk("wb_pc", pc, m_pc);
    start = 1'b0;
    @(negedge clk);
    m_pc = m_pc + STEP;
    if (m_instret != 32'hFFFF_FFFF) m_instret = m_instret + 32'd1;
    chk("post_wb_pc", pc, m_pc);
    chk("post_wb_instret", instret, exp_instret());
    halt_req = 1'b0;
    if (hlt) begin
      chk("halt_busy", busy, 1'b0);
      chk("halt_req", bus.imem_req, 1'b0);
      halted = 1'b1;
    end
  endtask

  initial begin
    bit h;
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; dec_legal = 1'b1; dec_wb_we = 1'b0;
    bus.imem_valid = 1'b0; bus.imem_rdata = '0;
    start2 = 1'b0; bus2.imem_valid = 1'b1; bus2.imem_rdata = 32'h0000_0013;
    model_reset();
    @(negedge clk);
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_ir", dec_instr, 32'd0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_strobes", {rf_re, alu_en, rf_we}, 3'b000);
    rst_n = 1'b1;
    idle_check(3);

    // Zero-wait legal stream: addresses 0,4,8 with rf_we every fourth cycle.
    start_seq(1'b1);
    for (int i = 0; i < 3; i++) do_instr(0, 1'b1, 1'b1, 1'b0, h);

    for (int i = 0; i < 60; i++) begin
      do_instr(int'($urandom_range(0, 3)), ($urandom_range(0, 9) != 0), 1'($urandom),
               ($urandom_range(0, 6) == 0), h);
      if (h) begin
        idle_check(2);
        start_seq(1'b0);
      end
    end

    // Halt after pc=4, then an illegal opcode at pc=8, then a clean refetch of 8.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    start_seq(1'b1);
    do_instr(0, 1'b1, 1'b1, 1'b0, h);
    do_instr(1, 1'b1, 1'b0, 1'b1, h);
    chk("halted_at_8", h, 1'b1);
    idle_check(3);
    start_seq(1'b0);
    do_instr(2, 1'b0, 1'b1, 1'b0, h);
    chk("illegal_halt", h, 1'b1);
    chk("illegal_pc", pc, 32'd8);
    idle_check(2);
    start_seq(1'b0);
    do_instr(3, 1'b1, 1'b1, 1'b0, h);
    chk("refetch_pc", pc, 32'd12);

    // Asynchronous reset in the middle of a waiting fetch.
    bus.imem_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", bus.imem_req, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_pc", pc, RST_PC);
    chk("async_ir", dec_instr, 32'd0);
    chk("async_illegal", illegal, 1'b0);
    chk("async_instret", instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    start = 1'b0;
    idle_check(3);
    start_seq(1'b1);
    do_instr(0, 1'b1, 1'b1, 1'b0, h);

    // Wrap from FFFF_FFFC to zero on the second instance.
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("wrap_pc0", pc2, 32'hFFFF_FFF8);
    repeat (4) @(negedge clk);
    chk("wrap_pc1", pc2, 32'hFFFF_FFFC);
    repeat (4) @(negedge clk);
    chk("wrap_pc2", pc2, 32'h0000_0000);
    chk("wrap_addr2", bus2.imem_addr, 32'h0000_0000);
    chk("wrap_illegal", illegal2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
